// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register and its forwarding unit.
package id_ex_stage_pkg;

    // Default widths for operands and register-file addresses.
    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int CTRL_W_DEF     = 8;

    // Register 0 is hard-wired to zero: it is never forwarded and never causes a hazard.
    localparam int REG_ZERO = 0;

    // EX operand-mux select encoding; 2'b11 is never driven.
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Forwarding select generation for both EX operands (purely combinational).
module id_ex_stage_forward_unit
    import id_ex_stage_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] ex_rs_addr,
    input  logic [REG_ADDR_W-1:0] ex_rt_addr,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b
);

    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(REG_ZERO);

    // A writer is eligible only if it actually writes a non-zero register.
    logic exmem_live;
    logic memwb_live;

    assign exmem_live = exmem_reg_write && (exmem_rd != ZERO_ADDR);
    assign memwb_live = memwb_reg_write && (memwb_rd != ZERO_ADDR);

    // Operand A select: the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        // NOTE: default first so every path assigns the output and no latch is inferred.
        fwd_sel_a = FWD_REGFILE;
        if (exmem_live && (exmem_rd == ex_rs_addr)) begin
            fwd_sel_a = FWD_EXMEM;
        end else if (memwb_live && (memwb_rd == ex_rs_addr)) begin
            fwd_sel_a = FWD_MEMWB;
        end
    end

    // Operand B select: same priority rule on the rt source.
    always_comb begin
        fwd_sel_b = FWD_REGFILE;
        if (exmem_live && (exmem_rd == ex_rt_addr)) begin
            fwd_sel_b = FWD_EXMEM;
        end else if (memwb_live && (memwb_rd == ex_rt_addr)) begin
            fwd_sel_b = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall, flush, load-use bubble insertion and
// forwarding-select generation for the EX operand muxes.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CTRL_W     = CTRL_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [CTRL_W-1:0]     id_ctrl,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic [REG_ADDR_W-1:0] ex_rs_addr,
    output logic [REG_ADDR_W-1:0] ex_rt_addr,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [DATA_W-1:0]     ex_rs_data,
    output logic [DATA_W-1:0]     ex_rt_data,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [CTRL_W-1:0]     ex_ctrl,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic                  hazard_stall
);

    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(REG_ZERO);

    // Load-use hazard: a live load in EX targets a register the ID instruction reads.
    // Kept asserted even under flush; the upstream consumer merges it with its own flush.
    assign hazard_stall = ex_valid && ex_mem_read && ex_reg_write &&
                          (ex_rd != ZERO_ADDR) && id_valid &&
                          ((ex_rd == id_rs_addr) || (ex_rd == id_rt_addr));

    // Pipeline register: flush > stall > hazard bubble > normal load.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_rs_addr   <= '0;
            ex_rt_addr   <= '0;
            ex_rd        <= '0;
            ex_rs_data   <= '0;
            ex_rt_data   <= '0;
            ex_imm       <= '0;
            ex_ctrl      <= '0;
        end else if (flush || (!stall && hazard_stall)) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_rs_addr   <= '0;
            ex_rt_addr   <= '0;
            ex_rd        <= '0;
            ex_rs_data   <= '0;
            ex_rt_data   <= '0;
            ex_imm       <= '0;
            ex_ctrl      <= '0;
        end else if (!stall) begin
            ex_valid     <= id_valid;
            ex_reg_write <= id_reg_write;
            ex_mem_read  <= id_mem_read;
            ex_rs_addr   <= id_rs_addr;
            ex_rt_addr   <= id_rt_addr;
            ex_rd        <= id_rd_addr;
            ex_rs_data   <= id_rs_data;
            ex_rt_data   <= id_rt_data;
            ex_imm       <= id_imm;
            ex_ctrl      <= id_ctrl;
        end
    end

    id_ex_stage_forward_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) forward_unit (
        .ex_rs_addr      (ex_rs_addr),
        .ex_rt_addr      (ex_rt_addr),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .fwd_sel_a       (fwd_sel_a),
        .fwd_sel_b       (fwd_sel_b)
    );

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a behavioural model.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_read;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [7:0]  ctrl;
    } ex_model_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic [4:0]  id_rd_addr;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [7:0]  id_ctrl;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic        ex_valid;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [4:0]  ex_rs_addr;
    logic [4:0]  ex_rt_addr;
    logic [4:0]  ex_rd;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [31:0] ex_imm;
    logic [7:0]  ex_ctrl;
    logic [1:0]  fwd_sel_a;
    logic [1:0]  fwd_sel_b;
    logic        hazard_stall;

    int total = 0;
    int bad   = 0;
    ex_model_t m;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .id_valid        (id_valid),
        .id_rs_addr      (id_rs_addr),
        .id_rt_addr      (id_rt_addr),
        .id_rd_addr      (id_rd_addr),
        .id_rs_data      (id_rs_data),
        .id_rt_data      (id_rt_data),
        .id_imm          (id_imm),
        .id_ctrl         (id_ctrl),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .ex_valid        (ex_valid),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_rs_addr      (ex_rs_addr),
        .ex_rt_addr      (ex_rt_addr),
        .ex_rd           (ex_rd),
        .ex_rs_data      (ex_rs_data),
        .ex_rt_data      (ex_rt_data),
        .ex_imm          (ex_imm),
        .ex_ctrl         (ex_ctrl),
        .fwd_sel_a       (fwd_sel_a),
        .fwd_sel_b       (fwd_sel_b),
        .hazard_stall    (hazard_stall)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Load-use rule as stated: a live load in EX writing a non-zero register read by ID.
    function automatic logic model_hazard(input ex_model_t s);
        if (!(s.valid && s.mem_read && s.reg_write) || s.rd == 5'd0 || !id_valid) return 1'b0;
        return (s.rd == id_rs_addr) || (s.rd == id_rt_addr);
    endfunction

    // Source for an EX operand: 2 = EX/MEM, 1 = MEM/WB, 0 = register file.
    function automatic logic [1:0] model_fwd(input logic [4:0] src);
        if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == src) return 2'd2;
        if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == src) return 2'd1;
        return 2'd0;
    endfunction

    task automatic check_comb(input string tag);
        check({tag, ".haz"},  hazard_stall, model_hazard(m));
        check({tag, ".sela"}, fwd_sel_a, model_fwd(m.rs));
        check({tag, ".selb"}, fwd_sel_b, model_fwd(m.rt));
    endtask

    task automatic check_regs(input string tag, input ex_model_t e);
        check({tag, ".flags"}, {ex_valid, ex_reg_write, ex_mem_read}, {e.valid, e.reg_write, e.mem_read});
        check({tag, ".addr"},  {ex_rs_addr, ex_rt_addr, ex_rd}, {e.rs, e.rt, e.rd});
        check({tag, ".data"},  {ex_rs_data, ex_rt_data, ex_imm}, {e.rs_data, e.rt_data, e.imm});
        check({tag, ".ctrl"},  ex_ctrl, e.ctrl);
    endtask

    // One clock: check combinational outputs, advance the model, check registers.
    task automatic cycle(input string tag);
        logic haz;
        #1;
        check_comb(tag);
        haz = model_hazard(m);
        @(posedge clk);
        if (flush)      m = '0;
        else if (stall) m = m;
        else if (haz)   m = '0;
        else            m = '{id_valid, id_reg_write, id_mem_read, id_rs_addr, id_rt_addr,
                              id_rd_addr, id_rs_data, id_rt_data, id_imm, id_ctrl};
        #1;
        check_regs(tag, m);
    endtask

    task automatic rand_inputs();
        id_valid        = ($urandom_range(0, 7) != 0);
        id_rs_addr      = 5'($urandom_range(0, 7));
        id_rt_addr      = 5'($urandom_range(0, 7));
        id_rd_addr      = 5'($urandom_range(0, 7));
        id_rs_data      = $urandom;
        id_rt_data      = $urandom;
        id_imm          = $urandom;
        id_ctrl         = 8'($urandom);
        id_reg_write    = ($urandom_range(0, 3) != 0);
        id_mem_read     = ($urandom_range(0, 2) == 0);
        exmem_reg_write = 1'($urandom);
        exmem_rd        = 5'($urandom_range(0, 7));
        memwb_reg_write = 1'($urandom);
        memwb_rd        = 5'($urandom_range(0, 7));
        stall           = ($urandom_range(0, 4) == 0);
        flush           = ($urandom_range(0, 9) == 0);
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic rw, input logic mr);
        id_valid     = 1'b1;
        id_rs_addr   = rs;
        id_rt_addr   = rt;
        id_rd_addr   = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
    endtask

    initial begin
        ex_model_t snap;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        id_valid = 1'b0; id_rs_addr = '0; id_rt_addr = '0; id_rd_addr = '0;
        id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_ctrl = '0;
        id_reg_write = 1'b0; id_mem_read = 1'b0;
        exmem_reg_write = 1'b0; exmem_rd = '0; memwb_reg_write = 1'b0; memwb_rd = '0;
        m = '0;
        repeat (2) @(posedge clk);
        #1;
        check_regs("reset", '0);
        check("reset.haz", hazard_stall, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Pass-through with one-cycle latency.
        set_id(5'd3, 5'd4, 5'd9, 1'b1, 1'b0);
        id_rs_data = 32'h11; id_rt_data = 32'h22; id_imm = 32'hFFFF_FFF0; id_ctrl = 8'h5A;
        cycle("pass");
        check("pass.valid", ex_valid, 1'b1);
        check("pass.imm", ex_imm, 32'hFFFF_FFF0);

        // Asynchronous reset mid-cycle while EX holds a valid instruction.
        #2 rst = 1'b1;
        #1;
        m = '0;
        check_regs("async_rst", '0);
        check("async_rst.sel", {fwd_sel_a, fwd_sel_b, hazard_stall}, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        set_id(5'd5, 5'd6, 5'd1, 1'b1, 1'b0);
        cycle("post_rst");

        // Forwarding priority on operand A (ex_rs_addr = 5).
        id_valid = 1'b0;
        exmem_reg_write = 1'b1; exmem_rd = 5'd5; memwb_reg_write = 1'b1; memwb_rd = 5'd5;
        #1 check("fwd.both", fwd_sel_a, 2'b10);
        exmem_reg_write = 1'b0;
        #1 check("fwd.memwb", fwd_sel_a, 2'b01);
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        #1 check("fwd.zero", fwd_sel_a, 2'b00);
        exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;

        // Load-use: load to r7 in EX, consumer reads r7 in ID.
        set_id(5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
        cycle("load");
        set_id(5'd7, 5'd3, 5'd8, 1'b1, 1'b0);
        #1 check("lu.haz", hazard_stall, 1'b1);
        cycle("lu.bubble");
        check("lu.bubble_valid", ex_valid, 1'b0);
        check("lu.haz_clear", hazard_stall, 1'b0);
        cycle("lu.reload");
        check("lu.loaded", {ex_valid, ex_rs_addr}, {1'b1, 5'd7});

        // Stall for three cycles while ID inputs change.
        snap = m;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            stall = 1'b1; flush = 1'b0;
            cycle("stall");
        end
        check_regs("stall.hold", snap);

        // Flush together with stall loads a bubble.
        set_id(5'd2, 5'd3, 5'd4, 1'b1, 1'b0);
        stall = 1'b1; flush = 1'b1;
        cycle("flush_stall");
        check("flush_stall.flags", {ex_valid, ex_reg_write}, 2'b00);
        stall = 1'b0; flush = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
